// File: rtl/lsu_axi_st_seq_if.sv
// AXI write request/response bundle between the LSU store sequencer
// and the AXI write interface.
interface lsu_axi_st_seq_if #(
    parameter int ORAM_AW = 12,
    parameter int AXI_AW  = 10,
    parameter int DW      = 64
);
    logic [7:0]         lsu_axi_awid;
    logic [AXI_AW-1:0]  lsu_axi_awaddr;
    logic [7:0]         lsu_axi_awlen;
    logic [2:0]         lsu_axi_awsize;
    logic [1:0]         lsu_axi_awburst;
    logic [2:0]         lsu_axi_awstr;
    logic               lsu_axi_awvld;
    logic [ORAM_AW-1:0] lsu_axi_oram_addr;
    logic               axi_lsu_awrdy;
    logic [DW-1:0]      lsu_axi_wdata;
    logic [DW/8-1:0]    lsu_axi_wstrb;
    logic               lsu_axi_wlast;
    logic               lsu_axi_wvld;
    logic               axi_lsu_wrdy;
    logic               axi_lsu_bvld;
    logic [1:0]         axi_lsu_bresp;
    logic [ORAM_AW-1:0] axi_lsu_resp_oram_addr;
    logic               lsu_axi_brdy;

    modport master (
        output lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen,
        output lsu_axi_awsize, lsu_axi_awburst, lsu_axi_awstr,
        output lsu_axi_awvld, lsu_axi_oram_addr,
        input  axi_lsu_awrdy,
        output lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast,
        output lsu_axi_wvld,
        input  axi_lsu_wrdy,
        input  axi_lsu_bvld, axi_lsu_bresp, axi_lsu_resp_oram_addr,
        output lsu_axi_brdy
    );

    modport slave (
        input  lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen,
        input  lsu_axi_awsize, lsu_axi_awburst, lsu_axi_awstr,
        input  lsu_axi_awvld, lsu_axi_oram_addr,
        output axi_lsu_awrdy,
        input  lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast,
        input  lsu_axi_wvld,
        output axi_lsu_wrdy,
        output axi_lsu_bvld, axi_lsu_bresp, axi_lsu_resp_oram_addr,
        input  lsu_axi_brdy
    );
endinterface

// File: rtl/lsu_axi_st_seq.sv
// LSU store sequencer: turns one strided store command into AXI AW
// bursts and W beats streamed from the output RAM, then drains B.
module lsu_axi_st_seq #(
    parameter int ORAM_AW = 12,
    parameter int AXI_AW  = 10,
    parameter int DW      = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_req_vld,
    output logic               st_req_rdy,
    input  logic [AXI_AW-1:0]  st_base_addr,
    input  logic [2:0]         st_stride,
    input  logic [3:0]         st_num,
    input  logic [7:0]         st_len,
    input  logic [ORAM_AW-1:0] st_oram_addr,
    output logic               st_done,
    output logic               st_err,
    output logic [ORAM_AW-1:0] st_err_oram_addr,
    output logic               oram_rd_en,
    output logic [ORAM_AW-1:0] oram_rd_addr,
    input  logic [DW-1:0]      oram_rd_data,
    lsu_axi_st_seq_if.master   axi
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WAITB = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ORAM_AW-1:0] ORAM_ONE = ORAM_AW'(1);

    logic [1:0]         r_state;
    logic [3:0]         r_num;
    logic [7:0]         r_len;
    logic [AXI_AW-1:0]  r_step;
    logic [AXI_AW-1:0]  r_awaddr;
    logic [ORAM_AW-1:0] r_aw_oram;
    logic               r_awvld;
    logic [4:0]         r_aw_cnt;
    logic [ORAM_AW-1:0] r_rd_addr;
    logic [7:0]         r_rd_beat;
    logic [4:0]         r_rd_burst;
    logic               r_infl;
    logic               r_infl_last;
    logic [DW-1:0]      r_fdata [2];
    logic [1:0]         r_flast;
    logic               r_wp;
    logic               r_rp;
    logic [1:0]         r_fcnt;
    logic [4:0]         r_w_burst;
    logic [4:0]         r_b_cnt;
    logic               r_err;
    logic [ORAM_AW-1:0] r_err_addr;

    logic               w_idle;
    logic               w_run;
    logic               w_acc;
    logic               w_aw_hs;
    logic               w_wvld;
    logic               w_w_hs;
    logic               w_head_last;
    logic               w_w_fin;
    logic               w_brdy;
    logic               w_b_hs;
    logic [4:0]         w_num1;
    logic               w_rd_en;
    logic               w_rd_last;
    logic [2:0]         w_occ;
    logic [AXI_AW-1:0]  w_step;

    assign w_idle      = (r_state == S_IDLE);
    assign w_run       = (r_state == S_RUN);
    assign w_acc       = w_idle & st_req_vld;
    assign w_aw_hs     = r_awvld & axi.axi_lsu_awrdy;
    assign w_wvld      = (r_fcnt != 2'd0);
    assign w_w_hs      = w_wvld & axi.axi_lsu_wrdy;
    assign w_head_last = r_flast[r_rp];
    assign w_w_fin     = w_w_hs & w_head_last
                       & (r_w_burst == {1'b0, r_num});
    assign w_brdy      = w_run | (r_state == S_WAITB);
    assign w_b_hs      = axi.axi_lsu_bvld & w_brdy;
    assign w_num1      = {1'b0, r_num} + 5'd1;

    // Occupancy plus the read in flight must stay below the FIFO depth.
    assign w_occ       = {1'b0, r_fcnt} + {2'b00, r_infl};
    assign w_rd_last   = (r_rd_beat == r_len);
    assign w_rd_en     = w_run & (r_rd_burst < r_aw_cnt)
                       & (w_occ < 3'd2);

    always_comb begin
        w_step = AXI_AW'(16);
        case (st_stride)
            3'b001:  w_step = AXI_AW'(32);
            3'b010:  w_step = AXI_AW'(64);
            3'b011:  w_step = AXI_AW'(128);
            3'b100:  w_step = AXI_AW'(256);
            default: w_step = AXI_AW'(16);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (st_req_vld) r_state <= S_RUN;
                S_RUN:   if (w_w_fin) r_state <= S_WAITB;
                S_WAITB: if (r_b_cnt == w_num1) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num     <= '0;
            r_len     <= '0;
            r_step    <= '0;
            r_awaddr  <= '0;
            r_aw_oram <= '0;
            r_awvld   <= 1'b0;
            r_aw_cnt  <= '0;
        end else if (w_acc) begin
            r_num     <= st_num;
            r_len     <= st_len;
            r_step    <= w_step;
            r_awaddr  <= st_base_addr;
            r_aw_oram <= st_oram_addr;
            r_awvld   <= 1'b0;
            r_aw_cnt  <= '0;
        end else if (w_run) begin
            if (w_aw_hs) begin
                r_aw_cnt  <= r_aw_cnt + 5'd1;
                r_awaddr  <= r_awaddr + r_step;
                r_aw_oram <= r_aw_oram + ORAM_AW'(r_len) + ORAM_ONE;
                r_awvld   <= (r_aw_cnt[3:0] != r_num);
            end else if (r_aw_cnt == 5'd0) begin
                r_awvld   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr   <= '0;
            r_rd_beat   <= '0;
            r_rd_burst  <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_infl      <= w_rd_en;
            r_infl_last <= w_rd_en & w_rd_last;
            if (w_acc) begin
                r_rd_addr  <= st_oram_addr;
                r_rd_beat  <= '0;
                r_rd_burst <= '0;
            end else if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + ORAM_ONE;
                if (w_rd_last) begin
                    r_rd_beat  <= '0;
                    r_rd_burst <= r_rd_burst + 5'd1;
                end else begin
                    r_rd_beat  <= r_rd_beat + 8'd1;
                end
            end
        end
    end

    // RAM data lands one cycle after the read; the FIFO tags burst ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_fdata[i] <= '0;
            r_flast   <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_fcnt    <= '0;
            r_w_burst <= '0;
        end else begin
            if (r_infl) begin
                r_fdata[r_wp] <= oram_rd_data;
                r_flast[r_wp] <= r_infl_last;
                r_wp          <= ~r_wp;
            end
            if (w_w_hs) r_rp <= ~r_rp;
            case ({r_infl, w_w_hs})
                2'b10:   r_fcnt <= r_fcnt + 2'd1;
                2'b01:   r_fcnt <= r_fcnt - 2'd1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_acc) begin
                r_w_burst <= '0;
            end else if (w_w_hs & w_head_last) begin
                r_w_burst <= r_w_burst + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_cnt    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_acc) begin
            r_b_cnt    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_b_hs) begin
            r_b_cnt <= r_b_cnt + 5'd1;
            if ((axi.axi_lsu_bresp != 2'b00) && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= axi.axi_lsu_resp_oram_addr;
            end
        end
    end

    assign st_req_rdy       = w_idle;
    assign st_done          = (r_state == S_DONE);
    assign st_err           = st_done & r_err;
    assign st_err_oram_addr = r_err_addr;
    assign oram_rd_en       = w_rd_en;
    assign oram_rd_addr     = r_rd_addr;

    assign axi.lsu_axi_awid      = {4'b0000, r_aw_cnt[3:0]};
    assign axi.lsu_axi_awaddr    = r_awaddr;
    assign axi.lsu_axi_awlen     = r_len;
    assign axi.lsu_axi_awsize    = 3'b011;
    assign axi.lsu_axi_awburst   = 2'b01;
    assign axi.lsu_axi_awstr     = 3'b000;
    assign axi.lsu_axi_awvld     = r_awvld;
    assign axi.lsu_axi_oram_addr = r_aw_oram;
    assign axi.lsu_axi_wdata     = r_fdata[r_rp];
    assign axi.lsu_axi_wstrb     = '1;
    assign axi.lsu_axi_wlast     = w_head_last;
    assign axi.lsu_axi_wvld      = w_wvld;
    assign axi.lsu_axi_brdy      = w_brdy;

endmodule

// File: tb/tb_lsu_axi_st_seq.sv
// Randomised scoreboard bench for lsu_axi_st_seq with an AXI slave
// model, an output-RAM model and a command-level reference model.
`timescale 1ns/1ps
module tb_lsu_axi_st_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_req_vld;
    logic        st_req_rdy;
    logic [9:0]  st_base_addr;
    logic [2:0]  st_stride;
    logic [3:0]  st_num;
    logic [7:0]  st_len;
    logic [11:0] st_oram_addr;
    logic        st_done;
    logic        st_err;
    logic [11:0] st_err_oram_addr;
    logic        oram_rd_en;
    logic [11:0] oram_rd_addr;
    logic [63:0] oram_rd_data;

    lsu_axi_st_seq_if ax ();

    lsu_axi_st_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .st_req_vld       (st_req_vld),
        .st_req_rdy       (st_req_rdy),
        .st_base_addr     (st_base_addr),
        .st_stride        (st_stride),
        .st_num           (st_num),
        .st_len           (st_len),
        .st_oram_addr     (st_oram_addr),
        .st_done          (st_done),
        .st_err           (st_err),
        .st_err_oram_addr (st_err_oram_addr),
        .oram_rd_en       (oram_rd_en),
        .oram_rd_addr     (oram_rd_addr),
        .oram_rd_data     (oram_rd_data),
        .axi              (ax)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a;
        logic [11:0] o;
        logic [7:0]  id;
        logic [7:0]  len;
    } aw_t;
    typedef struct {
        logic [63:0] d;
        logic        last;
        int          g;
    } w_t;
    typedef struct {
        logic [1:0]  r;
        logic [11:0] o;
    } rs_t;
    typedef struct {
        logic        e;
        logic [11:0] o;
    } dn_t;

    aw_t aw_q [$];
    w_t  w_q [$];
    rs_t rsp_q [$];
    dn_t done_q [$];
    logic [11:0] rd_q [$];

    logic [1:0]  cfg_br [16];
    logic [11:0] cfg_ro [16];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int g_next = 0;
    int aw_tot = 0;
    int rd_tot = 0;
    int w_tot = 0;
    int b_owed = 0;
    int done_cyc = -10;
    int acc_cyc = 0;
    int mode = 0;

    function automatic logic [63:0] ramf(input logic [11:0] a);
        return {a, 4'hA, ~a, 4'h5, a ^ 12'h5A5, 8'h3C, a, 4'h0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Command-level model: whole bursts and beats from the address rules.
    function automatic void model(input logic [9:0] base,
                                  input logic [2:0] s,
                                  input logic [3:0] num,
                                  input logic [7:0] len,
                                  input logic [11:0] oram);
        int step;
        int nb;
        int bl;
        bit e;
        logic [11:0] ea;
        step = (s <= 3'd4) ? (16 << s) : 16;
        nb = int'(num) + 1;
        bl = int'(len) + 1;
        e = 1'b0;
        ea = '0;
        for (int k = 0; k < nb; k++) begin
            aw_t a;
            a.a = 10'((int'(base) + k * step) % 1024);
            a.o = 12'((int'(oram) + k * bl) % 4096);
            a.id = 8'(k);
            a.len = len;
            aw_q.push_back(a);
            for (int i = 0; i < bl; i++) begin
                logic [11:0] ad;
                w_t w;
                ad = 12'((int'(oram) + k * bl + i) % 4096);
                rd_q.push_back(ad);
                w.d = ramf(ad);
                w.last = (i == bl - 1);
                w.g = g_next;
                w_q.push_back(w);
            end
            g_next++;
            rsp_q.push_back('{cfg_br[k], cfg_ro[k]});
            if (!e && cfg_br[k] != 2'b00) begin
                e = 1'b1;
                ea = cfg_ro[k];
            end
        end
        done_q.push_back('{e, ea});
    endfunction

    task automatic setcfg(input int errpct);
        for (int k = 0; k < 16; k++) begin
            cfg_br[k] = ($urandom_range(0, 99) < errpct)
                      ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_ro[k] = 12'($urandom);
        end
    endtask

    task automatic send(input logic [9:0] base, input logic [2:0] s,
                        input logic [3:0] num, input logic [7:0] len,
                        input logic [11:0] oram);
        int t;
        t = 0;
        @(negedge clk);
        st_base_addr = base;
        st_stride = s;
        st_num = num;
        st_len = len;
        st_oram_addr = oram;
        st_req_vld = 1'b1;
        while (!st_req_rdy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("cmd_accept_timeout", 0, 1);
        acc_cyc = cyc;
        model(base, s, num, len, oram);
        @(posedge clk);
        #1 st_req_vld = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((done_q.size() > 0 || w_q.size() > 0) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 6000) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (oram_rd_en) oram_rd_data <= ramf(oram_rd_addr);
    end

    // AXI slave: ready and response drivers, all moved on the falling edge.
    initial begin
        int aw_wait;
        int aw_dly;
        int b_wait;
        int b_dly;
        bit b_fire;
        aw_wait = 0;
        aw_dly = 0;
        b_wait = 0;
        b_dly = 0;
        b_fire = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ax.axi_lsu_awrdy = 1'b0;
                ax.axi_lsu_wrdy = 1'b0;
                ax.axi_lsu_bvld = 1'b0;
                ax.axi_lsu_bresp = 2'b00;
                ax.axi_lsu_resp_oram_addr = '0;
                b_fire = 1'b0;
                aw_wait = 0;
                b_wait = 0;
            end else begin
                if (b_fire) begin
                    void'(rsp_q.pop_front());
                    b_owed--;
                    ax.axi_lsu_bvld = 1'b0;
                end
                if (!ax.axi_lsu_bvld && b_owed > 0 && rsp_q.size() > 0) begin
                    if (b_wait >= b_dly) begin
                        ax.axi_lsu_bvld = 1'b1;
                        ax.axi_lsu_bresp = rsp_q[0].r;
                        ax.axi_lsu_resp_oram_addr = rsp_q[0].o;
                        b_wait = 0;
                        b_dly = (mode == 0) ? 0 : $urandom_range(0, 4);
                    end else begin
                        b_wait++;
                    end
                end
                b_fire = ax.axi_lsu_bvld && ax.lsu_axi_brdy;
                if (ax.lsu_axi_awvld) begin
                    ax.axi_lsu_awrdy = (aw_wait >= aw_dly);
                    if (ax.axi_lsu_awrdy) begin
                        aw_wait = 0;
                        aw_dly = (mode == 2) ? 5
                               : (mode == 1) ? $urandom_range(0, 3) : 0;
                    end else begin
                        aw_wait++;
                    end
                end else begin
                    ax.axi_lsu_awrdy = 1'b0;
                    if (mode == 2) aw_dly = 5;
                end
                case (mode)
                    1:       ax.axi_lsu_wrdy = ($urandom_range(0, 3) != 0);
                    2:       ax.axi_lsu_wrdy = ~ax.axi_lsu_wrdy;
                    default: ax.axi_lsu_wrdy = 1'b1;
                endcase
            end
        end
    end

    // Monitor: compares whatever the DUT hands over at the coming edge.
    initial begin
        aw_t a;
        w_t w;
        dn_t dn;
        logic [11:0] ra;
        logic p_awvld, p_awrdy, p_wvld, p_wrdy, p_wlast;
        logic [9:0] p_awaddr;
        logic [11:0] p_awor;
        logic [7:0] p_awid;
        logic [63:0] p_wdata;
        p_awvld = 0; p_awrdy = 0; p_wvld = 0; p_wrdy = 0; p_wlast = 0;
        p_awaddr = 0; p_awor = 0; p_awid = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                p_awvld = 0;
                p_wvld = 0;
            end else begin
                if (p_wvld && !p_wrdy) begin
                    chk("w_hold_vld", ax.lsu_axi_wvld, 1);
                    chk("w_hold_data", ax.lsu_axi_wdata, p_wdata);
                    chk("w_hold_last", ax.lsu_axi_wlast, p_wlast);
                end
                if (ax.lsu_axi_wvld && ax.axi_lsu_wrdy) begin
                    w_tot++;
                    if (w_q.size() == 0) begin
                        chk("w_extra_beat", 1, 0);
                    end else begin
                        w = w_q.pop_front();
                        chk("w_data", ax.lsu_axi_wdata, w.d);
                        chk("w_last", ax.lsu_axi_wlast, w.last);
                        chk("w_after_aw", (w.g < aw_tot), 1);
                        if (w.last) b_owed++;
                    end
                end
                if (p_awvld && !p_awrdy) begin
                    chk("aw_hold", {ax.lsu_axi_awvld, ax.lsu_axi_awaddr,
                        ax.lsu_axi_oram_addr, ax.lsu_axi_awid},
                        {1'b1, p_awaddr, p_awor, p_awid});
                end
                if (ax.lsu_axi_awvld && ax.axi_lsu_awrdy) begin
                    aw_tot++;
                    if (aw_q.size() == 0) begin
                        chk("aw_extra", 1, 0);
                    end else begin
                        a = aw_q.pop_front();
                        chk("aw_addr", ax.lsu_axi_awaddr, a.a);
                        chk("aw_oram", ax.lsu_axi_oram_addr, a.o);
                        chk("aw_id_len", {ax.lsu_axi_awid, ax.lsu_axi_awlen},
                            {a.id, a.len});
                    end
                end
                if (oram_rd_en) begin
                    rd_tot++;
                    if (rd_q.size() == 0) begin
                        chk("rd_extra", 1, 0);
                    end else begin
                        ra = rd_q.pop_front();
                        chk("rd_addr", oram_rd_addr, ra);
                    end
                    chk("rd_outstanding", (rd_tot - w_tot <= 2), 1);
                end
                if (st_done) begin
                    done_cyc = cyc;
                    if (done_q.size() == 0) begin
                        chk("done_extra", 1, 0);
                    end else begin
                        dn = done_q.pop_front();
                        chk("done_err", st_err, dn.e);
                        if (dn.e) chk("done_err_addr", st_err_oram_addr, dn.o);
                    end
                end
                p_awvld = ax.lsu_axi_awvld;
                p_awrdy = ax.axi_lsu_awrdy;
                p_awaddr = ax.lsu_axi_awaddr;
                p_awor = ax.lsu_axi_oram_addr;
                p_awid = ax.lsu_axi_awid;
                p_wvld = ax.lsu_axi_wvld;
                p_wrdy = ax.axi_lsu_wrdy;
                p_wdata = ax.lsu_axi_wdata;
                p_wlast = ax.lsu_axi_wlast;
            end
        end
    end

    task automatic flush_model();
        aw_q.delete();
        w_q.delete();
        rsp_q.delete();
        done_q.delete();
        rd_q.delete();
        b_owed = 0;
        rd_tot = 0;
        w_tot = 0;
        aw_tot = g_next;
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        st_req_vld = 1'b0;
        st_base_addr = '0;
        st_stride = '0;
        st_num = '0;
        st_len = '0;
        st_oram_addr = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_rdy", st_req_rdy, 1);
        chk("rst_valids", {ax.lsu_axi_awvld, ax.lsu_axi_wvld,
            ax.lsu_axi_brdy, oram_rd_en}, 0);
        chk("rst_done_err", {st_done, st_err, st_err_oram_addr}, 0);
        chk("rst_aw_fields", {ax.lsu_axi_awaddr, ax.lsu_axi_oram_addr,
            ax.lsu_axi_awid, oram_rd_addr}, 0);
        rst_n = 1'b1;

        mode = 0;
        setcfg(0);
        send(10'h040, 3'b000, 4'd0, 8'd3, 12'h010);
        wait_done();

        setcfg(0);
        send(10'h3C0, 3'b010, 4'd3, 8'd1, 12'hFFE);
        wait_done();

        mode = 2;
        setcfg(0);
        send(10'h100, 3'b001, 4'd2, 8'd3, 12'h200);
        wait_done();

        mode = 1;
        setcfg(0);
        cfg_br[1] = 2'b10;
        cfg_ro[1] = 12'h123;
        cfg_br[2] = 2'b11;
        cfg_ro[2] = 12'h456;
        send(10'h000, 3'b011, 4'd2, 8'd2, 12'h300);
        wait_done();

        mode = 0;
        setcfg(0);
        send(10'h080, 3'b000, 4'd3, 8'd7, 12'h400);
        t = 0;
        while (w_tot < 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("mid_run_timeout", 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", {ax.lsu_axi_awvld, ax.lsu_axi_wvld,
            ax.lsu_axi_brdy, oram_rd_en, st_done}, 0);
        flush_model();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", st_req_rdy, 1);
        setcfg(0);
        send(10'h200, 3'b100, 4'd1, 8'd2, 12'h500);
        wait_done();

        mode = 1;
        setcfg(20);
        send(10'h010, 3'b001, 4'd2, 8'd1, 12'h600);
        setcfg(20);
        send(10'h020, 3'b111, 4'd1, 8'd0, 12'h700);
        chk("b2b_accept_cycle", acc_cyc, done_cyc + 1);
        wait_done();

        for (int n = 0; n < 20; n++) begin
            mode = ($urandom_range(0, 3) == 0) ? 2 : 1;
            setcfg(15);
            if (n % 7 == 6) begin
                send(10'($urandom), 3'($urandom), 4'd15,
                     8'($urandom_range(0, 15)), 12'($urandom));
            end else begin
                send(10'($urandom), 3'($urandom),
                     4'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                     12'($urandom));
            end
            wait_done();
        end

        chk("end_aw_q", aw_q.size(), 0);
        chk("end_w_q", w_q.size(), 0);
        chk("end_rd_q", rd_q.size(), 0);
        chk("end_rsp_q", rsp_q.size(), 0);
        chk("end_idle", st_req_rdy, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
